// File: rtl/spi_adc_ctrl.sv
// SPI master for a 2-channel 12-bit SAR ADC (MCP3202-class), SPI mode 0,0.
// One start request runs one single-ended conversion on the selected channel
// and returns the result on data_o with a one-cycle eoc_o pulse.
module spi_adc_ctrl #(
  parameter int CLK_DIV = 25,
  parameter int DATA_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_i,
  input  logic              sel_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_o,
  output logic [DATA_W-1:0] data_o,
  output logic              eoc_o,
  output logic              busy_o
);

  // Frame: 4 command edges, 1 null-bit edge, then DATA_W data edges.
  localparam int N      = 5 + DATA_W;
  localparam int DIV_W  = $clog2(2 * CLK_DIV);
  localparam int EDGE_W = $clog2(N + 1);

  localparam logic [DIV_W-1:0]  HALF_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  GUARD_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(N);
  localparam logic [EDGE_W-1:0] EDGE_NULL  = EDGE_W'(5);
  localparam logic [EDGE_W-1:0] EDGE_CMD   = EDGE_W'(4);
  localparam logic [EDGE_W-1:0] EDGE_ONE   = EDGE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GUARD = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIV_W-1:0]    r_div;
  logic [EDGE_W-1:0]   r_edge;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_sel;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic                w_half_end;
  logic                w_guard_end;
  logic [3:0]          w_cmd;

  // Command word in transmit order: bit k goes out before rising edge k+1
  // (start, SGL/DIFF=single-ended, ODD/SIGN=channel, MSBF).
  assign w_cmd       = {1'b1, r_sel, 1'b1, 1'b1};
  assign w_half_end  = (r_div == HALF_LAST);
  assign w_guard_end = (r_div == GUARD_LAST);
  assign data_o      = r_data;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (st_i) w_next = S_SETUP;
      S_SETUP: if (w_half_end) w_next = S_SHIFT;
      S_SHIFT: if (w_half_end && !r_sclk && (r_edge == EDGE_LAST)) w_next = S_GUARD;
      S_GUARD: if (w_guard_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; sclk/mosi are gated by state so any non-frame state
  // (including unused encodings) presents reset-like pin values.
  always_comb begin
    cs_o   = 1'b1;
    busy_o = 1'b0;
    eoc_o  = 1'b0;
    sclk_o = 1'b0;
    mosi_o = 1'b0;
    case (r_state)
      S_SETUP: begin
        cs_o   = 1'b0;
        busy_o = 1'b1;
        mosi_o = r_mosi;
      end
      S_SHIFT: begin
        cs_o   = 1'b0;
        busy_o = 1'b1;
        sclk_o = r_sclk;
        mosi_o = r_mosi;
      end
      S_GUARD: busy_o = 1'b1;
      S_DONE:  eoc_o  = 1'b1;
      default: ;
    endcase
  end

  // Timing counters, SCLK/MOSI generation, MISO capture and result register.
  // The result is loaded on the GUARD->DONE edge so data_o is already valid
  // in the eoc_o cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_div   <= '0;
      r_edge  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_sel   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div  <= '0;
          r_edge <= '0;
          r_sclk <= 1'b0;
          r_mosi <= st_i;
          if (st_i) r_sel <= sel_i;
        end
        S_SETUP: begin
          if (w_half_end) begin
            r_div  <= '0;
            r_sclk <= 1'b1;
            r_edge <= EDGE_ONE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_half_end) begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_mosi <= (r_edge < EDGE_CMD) ? w_cmd[r_edge[1:0]] : 1'b0;
            end else if (r_edge != EDGE_LAST) begin
              r_sclk <= 1'b1;
              r_edge <= r_edge + 1'b1;
              // Rising edges after the null bit carry data, MSB first.
              if (r_edge >= EDGE_NULL) r_shift <= {r_shift[DATA_W-2:0], miso_i};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GUARD: begin
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          if (w_guard_end) begin
            r_div  <= '0;
            r_data <= r_shift;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DONE: r_div <= '0;
        default: begin
          r_div  <= '0;
          r_edge <= '0;
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_ctrl.sv
// Testbench for spi_adc_ctrl: directed sequence with randomized ADC values,
// an ADC pin model and a frame monitor feeding a behavioural reference.
module tb_spi_adc_ctrl;

  localparam int CLK_DIV = 25;
  localparam int DATA_W  = 12;
  localparam int NEDGE   = 5 + DATA_W;
  localparam int LAT     = 1 + CLK_DIV * (2 * NEDGE + 3);

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              st_i = 1'b0;
  logic              sel_i = 1'b0;
  logic              miso_i = 1'b0;
  logic              sclk_o, mosi_o, cs_o, eoc_o, busy_o;
  logic [DATA_W-1:0] data_o;

  spi_adc_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .st_i   (st_i),
    .sel_i  (sel_i),
    .miso_i (miso_i),
    .sclk_o (sclk_o),
    .mosi_o (mosi_o),
    .cs_o   (cs_o),
    .data_o (data_o),
    .eoc_o  (eoc_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / ADC model state (written only by the monitor process).
  logic              prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_eoc = 1'b0;
  int                evt_cyc = 0, cs_rise_cyc = 0, last_gap = 0, frise = 0;
  int                rises_total = 0, half_bad = 0, mosi_viol = 0, late_one = 0;
  int                eoc_total = 0, eoc_long = 0, eoc_busy = 0, last_eoc_cyc = 0;
  logic [3:0]        cmd_cap = '0;
  logic [DATA_W-1:0] last_eoc_data = '0;

  // Value the ADC converts; written only by the stimulus process.
  logic [DATA_W-1:0] adc_val = '0;

  // Pin monitor plus ADC: ADC updates Dout after each falling SCLK so the
  // bit is stable for the following rising edge.
  always @(negedge clk) begin
    int nxt;
    if (!cs_o && prev_cs) begin
      last_gap = cyc - cs_rise_cyc;
      evt_cyc  = cyc;
      frise    = 0;
      cmd_cap  = '0;
    end else if (cs_o && !prev_cs) begin
      if (cyc - evt_cyc != CLK_DIV) half_bad++;
      cs_rise_cyc = cyc;
      miso_i      = 1'b0;
    end
    if (sclk_o != prev_sclk) begin
      if (cyc - evt_cyc != CLK_DIV) half_bad++;
      evt_cyc = cyc;
      if (sclk_o) begin
        frise++;
        rises_total++;
        if (frise <= 4) cmd_cap[frise-1] = mosi_o;
        else if (mosi_o) late_one++;
      end else if (!cs_o) begin
        nxt    = frise + 1;
        miso_i = (nxt >= 6 && nxt <= NEDGE) ? adc_val[DATA_W-1-(nxt-6)] : 1'b0;
      end
    end
    if ((mosi_o !== prev_mosi) && sclk_o) mosi_viol++;
    if (eoc_o) begin
      eoc_total++;
      last_eoc_cyc  = cyc;
      last_eoc_data = data_o;
      if (prev_eoc) eoc_long++;
      if (busy_o)   eoc_busy++;
    end
    prev_cs   = cs_o;
    prev_sclk = sclk_o;
    prev_mosi = mosi_o;
    prev_eoc  = eoc_o;
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  int s_rises, s_half, s_viol, s_late, s_eoc, s_long, s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rises = rises_total; s_half = half_bad; s_viol = mosi_viol;
    s_late  = late_one;    s_eoc  = eoc_total; s_long = eoc_long; s_busy = eoc_busy;
  endtask

  task automatic do_start(input logic sel, output int t);
    @(posedge clk); #1;
    st_i = 1'b1; sel_i = sel; t = cyc;
    @(posedge clk); #1;
    st_i = 1'b0;
  endtask

  task automatic begin_frame(input logic sel, input logic [DATA_W-1:0] val,
                             input string nm, output int t);
    snap();
    adc_val = val;
    do_start(sel, t);
    chk({nm, "_busy_start"}, busy_o, 1);
    chk({nm, "_cs_start"}, cs_o, 0);
  endtask

  task automatic end_frame(input logic sel, input logic [DATA_W-1:0] val,
                           input int t, input string nm);
    bit got;
    logic [3:0] exp_cmd;
    got = 1'b0;
    for (int i = 0; i < LAT + 50 && !got; i++) begin
      @(negedge clk); #1;
      if (eoc_total != s_eoc) got = 1'b1;
    end
    // Edge order: start, single-ended, channel, MSB-first.
    exp_cmd = {1'b1, sel, 1'b1, 1'b1};
    chk({nm, "_eoc_seen"}, got, 1);
    chk({nm, "_latency"}, last_eoc_cyc - t, LAT);
    chk({nm, "_data_at_eoc"}, last_eoc_data, val);
    chk({nm, "_data_o"}, data_o, val);
    chk({nm, "_cmd_bits"}, cmd_cap, exp_cmd);
    chk({nm, "_sclk_rises"}, rises_total - s_rises, NEDGE);
    chk({nm, "_half_period_err"}, half_bad - s_half, 0);
    chk({nm, "_mosi_while_high"}, mosi_viol - s_viol, 0);
    chk({nm, "_mosi_after_cmd"}, late_one - s_late, 0);
  endtask

  task automatic settle(input logic [DATA_W-1:0] val, input string nm);
    repeat (3) begin @(negedge clk); #1; end
    chk({nm, "_eoc_count"}, eoc_total - s_eoc, 1);
    chk({nm, "_eoc_width"}, eoc_long - s_long, 0);
    chk({nm, "_busy_in_eoc"}, eoc_busy - s_busy, 0);
    chk({nm, "_data_held"}, data_o, val);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic rs;
    logic [DATA_W-1:0] rv, va, vb;

    // Reset held with a start request present.
    rst_i = 1'b0; st_i = 1'b1; sel_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs_o, 1);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_mosi", mosi_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_eoc", eoc_o, 0);
    chk("rst_data", data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b1; st_i = 1'b0; sel_i = 1'b0;
    repeat (30) begin @(negedge clk); #1; end
    chk("rst_no_frame_rises", rises_total, 0);
    chk("rst_no_frame_cs", cs_o, 1);

    // CH0 with fixed pattern.
    begin_frame(1'b0, 12'hA5C, "ch0_a5c", t);
    end_frame(1'b0, 12'hA5C, t, "ch0_a5c");
    settle(12'hA5C, "ch0_a5c");

    // CH1 all-ones then minimum non-zero.
    begin_frame(1'b1, 12'hFFF, "ch1_fff", t);
    end_frame(1'b1, 12'hFFF, t, "ch1_fff");
    settle(12'hFFF, "ch1_fff");
    begin_frame(1'b1, 12'h001, "ch1_001", t);
    end_frame(1'b1, 12'h001, t, "ch1_001");
    settle(12'h001, "ch1_001");

    // Randomized channel and value.
    for (int i = 0; i < 2; i++) begin
      rs = 1'($urandom_range(0, 1));
      rv = DATA_W'($urandom);
      begin_frame(rs, rv, "rand", t);
      end_frame(rs, rv, t, "rand");
      settle(rv, "rand");
    end

    // Start pulse and sel_i changes during a CH0 frame are ignored.
    rv = DATA_W'($urandom);
    begin_frame(1'b0, rv, "ignore", t);
    while (cyc < t + 100) begin @(posedge clk); #1; end
    st_i = 1'b1; sel_i = 1'b1;
    @(posedge clk); #1;
    st_i = 1'b0;
    while (cyc < t + 300) begin @(posedge clk); #1; end
    sel_i = ~sel_i;
    end_frame(1'b0, rv, t, "ignore");
    settle(rv, "ignore");
    repeat (60) begin @(negedge clk); #1; end
    chk("ignore_no_queued_frame", rises_total - s_rises, NEDGE);

    // Sequencer turnaround: CH1 start two cycles after CH0 eoc.
    va = DATA_W'($urandom);
    vb = DATA_W'($urandom_range(1, 4095));
    begin_frame(1'b0, va, "seq_ch0", t);
    end_frame(1'b0, va, t, "seq_ch0");
    @(posedge clk); #1;
    begin_frame(1'b1, vb, "seq_ch1", t);
    chk("seq_start_gap", t - last_eoc_cyc, 2);
    chk("seq_cs_high_ge_guard", (last_gap >= 2 * CLK_DIV), 1);
    end_frame(1'b1, vb, t, "seq_ch1");
    settle(vb, "seq_ch1");

    // Reset mid-frame aborts, then a clean CH1 conversion.
    rv = DATA_W'($urandom);
    begin_frame(1'b0, rv, "abort", t);
    while (cyc < t + 400) begin @(posedge clk); #1; end
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk); #1;
    chk("abort_cs", cs_o, 1);
    chk("abort_sclk", sclk_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_data_clr", data_o, 0);
    repeat (LAT + 20) begin @(negedge clk); #1; end
    chk("abort_no_eoc", eoc_total - s_eoc, 0);
    chk("abort_data_still_clr", data_o, 0);
    rv = DATA_W'($urandom);
    begin_frame(1'b1, rv, "post_abort", t);
    end_frame(1'b1, rv, t, "post_abort");
    settle(rv, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
